// File: rtl/ft245_pkt_pkg.sv
// Shared types and helpers for the FT245 packet deframer.
package ft245_pkt_pkg;

   // Parser states
   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } pkt_state_t;

   // Default frame start marker
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // One step of the running frame checksum (byte XOR)
   function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/ft245_pkt_ibuf.sv
// Small synchronous show-ahead FIFO buffering raw bytes from the RX FIFO port.
module ft245_pkt_ibuf #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       ft_clk,
   input  logic                       ft_rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge ft_clk or negedge ft_rst) begin
      if (!ft_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Read issue is throttled upstream, so a push into a full buffer is a design bug
   a_no_overflow: assert property (@(posedge ft_clk) disable iff (!ft_rst) !(push && full && !pop));

endmodule

// File: rtl/ft245_pkt_deframer.sv
// Parses SYNC/LEN/payload/CHK frames from the RX FIFO and emits payload as a valid/ready stream.
module ft245_pkt_deframer
   import ft245_pkt_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_DEFAULT,
   parameter int unsigned MAX_LEN    = 64,
   parameter int unsigned IBUF_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              ft_clk,
   input  logic              ft_rst,
   output logic              rxfifo_rd,
   input  logic [DATA_W-1:0] rxfifo_data,
   input  logic              rxfifo_valid,
   input  logic              rxfifo_empty,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              m_err,
   output logic [CNT_W-1:0]  frm_ok_cnt,
   output logic [CNT_W-1:0]  frm_err_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;
   localparam logic [CW-1:0]     IF_ONE   = CW'(1);
   localparam logic [CW:0]       OCC_MAX  = (CW + 1)'(IBUF_DEPTH);
   localparam logic [DATA_W-1:0] LEN_MAX  = DATA_W'(MAX_LEN);
   localparam logic [DATA_W-1:0] BYTE_ONE = DATA_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   pkt_state_t        state, state_nxt;

   logic [CW-1:0]     ib_cnt;
   logic              ib_empty;
   logic [DATA_W-1:0] ib_data;
   logic              ib_push;
   logic              pop;

   logic              rd_en;
   logic [CW-1:0]     inflight;
   logic [CW:0]       occupancy;

   logic [DATA_W-1:0] remaining;
   logic [DATA_W-1:0] xor_acc;
   logic [DATA_W-1:0] hold_data;
   logic              hold_vld;
   logic              out_space;

   logic              clr_xor, ld_len, ld_hold, clr_hold, ld_out;
   logic              out_last_nxt, out_err_nxt;
   logic              inc_ok, inc_err, inc_drop;

   // Read issue: keep buffered plus in-flight bytes within the buffer depth.
   // rd_en holds the strobe low while reset is asserted.
   assign occupancy = {1'b0, ib_cnt} + {1'b0, inflight};
   assign rxfifo_rd = rd_en && !rxfifo_empty && (occupancy < OCC_MAX);

   // Data returning with nothing outstanding belongs to reads issued before reset
   assign ib_push   = rxfifo_valid && (inflight != '0);
   assign out_space = !m_valid || m_ready;

   ft245_pkt_ibuf #(
      .DATA_W (DATA_W),
      .DEPTH  (IBUF_DEPTH)
   ) u_ibuf (
      .ft_clk    (ft_clk),
      .ft_rst    (ft_rst),
      .push      (ib_push),
      .push_data (rxfifo_data),
      .pop       (pop),
      .pop_data  (ib_data),
      .count     (ib_cnt),
      .empty     (ib_empty)
   );

   // Outstanding read tracking
   always_ff @(posedge ft_clk or negedge ft_rst) begin
      if (!ft_rst) begin
         rd_en    <= 1'b0;
         inflight <= '0;
      end else begin
         rd_en <= 1'b1;
         case ({rxfifo_rd, ib_push})
            2'b10:   inflight <= inflight + IF_ONE;
            2'b01:   inflight <= inflight - IF_ONE;
            default: inflight <= inflight;
         endcase
      end
   end

   // Parser state register
   always_ff @(posedge ft_clk or negedge ft_rst) begin
      if (!ft_rst) state <= ST_HUNT;
      else         state <= state_nxt;
   end

   // Parser next-state and per-cycle control strobes
   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      clr_xor      = 1'b0;
      ld_len       = 1'b0;
      ld_hold      = 1'b0;
      clr_hold     = 1'b0;
      ld_out       = 1'b0;
      out_last_nxt = 1'b0;
      out_err_nxt  = 1'b0;
      inc_ok       = 1'b0;
      inc_err      = 1'b0;
      inc_drop     = 1'b0;
      case (state)
         ST_HUNT: begin
            if (!ib_empty) begin
               pop = 1'b1;
               if (ib_data == SYNC_BYTE) begin
                  clr_xor   = 1'b1;
                  state_nxt = ST_LEN;
               end else begin
                  inc_drop = 1'b1;
               end
            end
         end
         ST_LEN: begin
            if (!ib_empty) begin
               pop = 1'b1;
               if ((ib_data == '0) || (ib_data > LEN_MAX)) begin
                  inc_err   = 1'b1;
                  state_nxt = ST_HUNT;
               end else begin
                  ld_len    = 1'b1;
                  state_nxt = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            // The newest byte waits in hold so the final beat can carry the CHK verdict
            if (!ib_empty && (!hold_vld || out_space)) begin
               pop     = 1'b1;
               ld_hold = 1'b1;
               ld_out  = hold_vld;
               if (remaining == BYTE_ONE) state_nxt = ST_CHK;
            end
         end
         ST_CHK: begin
            if (!ib_empty && out_space) begin
               pop          = 1'b1;
               clr_hold     = 1'b1;
               ld_out       = 1'b1;
               out_last_nxt = 1'b1;
               out_err_nxt  = (ib_data != xor_acc);
               inc_err      = (ib_data != xor_acc);
               inc_ok       = (ib_data == xor_acc);
               state_nxt    = ST_HUNT;
            end
         end
         default: state_nxt = ST_HUNT;
      endcase
   end

   // Frame datapath, output register and saturating statistics
   always_ff @(posedge ft_clk or negedge ft_rst) begin
      if (!ft_rst) begin
         remaining   <= '0;
         xor_acc     <= '0;
         hold_data   <= '0;
         hold_vld    <= 1'b0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         m_err       <= 1'b0;
         frm_ok_cnt  <= '0;
         frm_err_cnt <= '0;
         drop_cnt    <= '0;
      end else begin
         if (clr_xor) xor_acc <= '0;
         if (ld_len) begin
            remaining <= ib_data;
            xor_acc   <= ib_data;
         end
         if (ld_hold) begin
            hold_data <= ib_data;
            hold_vld  <= 1'b1;
            remaining <= remaining - BYTE_ONE;
            xor_acc   <= chk_step(xor_acc, ib_data);
         end else if (clr_hold) begin
            hold_vld <= 1'b0;
         end
         if (ld_out) begin
            m_valid <= 1'b1;
            m_data  <= hold_data;
            m_last  <= out_last_nxt;
            m_err   <= out_err_nxt;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
         if (inc_ok   && (frm_ok_cnt  != '1)) frm_ok_cnt  <= frm_ok_cnt  + CNT_ONE;
         if (inc_err  && (frm_err_cnt != '1)) frm_err_cnt <= frm_err_cnt + CNT_ONE;
         if (inc_drop && (drop_cnt    != '1)) drop_cnt    <= drop_cnt    + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_ft245_pkt_deframer.sv
// Directed bench for ft245_pkt_deframer: RX FIFO model, stream sink, hand-computed expectations.
module tb_ft245_pkt_deframer;

   logic        ft_clk;
   logic        ft_rst;
   logic        rxfifo_rd;
   logic [7:0]  rxfifo_data;
   logic        rxfifo_valid;
   logic        rxfifo_empty;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        m_err;
   logic [15:0] frm_ok_cnt;
   logic [15:0] frm_err_cnt;
   logic [15:0] drop_cnt;

   logic [7:0]  src_q [$];
   logic [7:0]  got_d [$];
   logic        got_l [$];
   logic        got_e [$];

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned rd_empty_viol;
   int unsigned stall_viol;
   int unsigned rdy_pct;

   ft245_pkt_deframer #(
      .DATA_W     (8),
      .SYNC_BYTE  (8'hA5),
      .MAX_LEN    (64),
      .IBUF_DEPTH (4),
      .CNT_W      (16)
   ) dut (
      .ft_clk       (ft_clk),
      .ft_rst       (ft_rst),
      .rxfifo_rd    (rxfifo_rd),
      .rxfifo_data  (rxfifo_data),
      .rxfifo_valid (rxfifo_valid),
      .rxfifo_empty (rxfifo_empty),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .m_err        (m_err),
      .frm_ok_cnt   (frm_ok_cnt),
      .frm_err_cnt  (frm_err_cnt),
      .drop_cnt     (drop_cnt)
   );

   initial begin
      ft_clk = 1'b0;
      forever #5 ft_clk = ~ft_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // RX FIFO model: data follows a read strobe by one cycle; empty moves only just after posedge
   initial begin
      logic       pend;
      logic [7:0] pend_d;
      pend = 1'b0;
      pend_d = 8'h00;
      rxfifo_valid = 1'b0;
      rxfifo_data = 8'h00;
      rxfifo_empty = 1'b1;
      forever begin
         @(negedge ft_clk);
         rxfifo_valid = pend;
         rxfifo_data  = pend ? pend_d : 8'h00;
         pend = 1'b0;
         if (rxfifo_rd) begin
            if (rxfifo_empty) rd_empty_viol++;
            else if (src_q.size() != 0) begin
               pend   = 1'b1;
               pend_d = src_q.pop_front();
            end
         end
         @(posedge ft_clk);
         #1;
         rxfifo_empty = (src_q.size() == 0);
      end
   end

   // Sink ready generator
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge ft_clk);
         #1;
         m_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99, 0) < rdy_pct);
      end
   end

   // Sink: record accepted beats and watch stability under backpressure
   initial begin
      logic       st_v;
      logic [7:0] st_d;
      logic       st_l, st_e;
      st_v = 1'b0;
      st_d = 8'h00;
      st_l = 1'b0;
      st_e = 1'b0;
      forever begin
         @(negedge ft_clk);
         if (ft_rst) begin
            if (st_v && !(m_valid && m_data == st_d && m_last == st_l && m_err == st_e))
               stall_viol++;
            if (m_valid && m_ready) begin
               got_d.push_back(m_data);
               got_l.push_back(m_last);
               got_e.push_back(m_err);
            end
            st_v = m_valid && !m_ready;
            st_d = m_data;
            st_l = m_last;
            st_e = m_err;
         end else begin
            st_v = 1'b0;
         end
      end
   end

   task automatic clear_beats();
      got_d.delete();
      got_l.delete();
      got_e.delete();
   endtask

   task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                             input int unsigned n);
      logic [7:0] arr [6];
      arr[0] = b0; arr[1] = b1; arr[2] = b2; arr[3] = b3; arr[4] = b4; arr[5] = b5;
      for (int unsigned i = 0; i < n; i++) src_q.push_back(arr[i]);
   endtask

   task automatic wait_beats(input string tag, input int unsigned n, input int unsigned budget);
      int unsigned c;
      c = 0;
      while (got_d.size() < n && c < budget) begin
         @(negedge ft_clk);
         c++;
      end
      if (got_d.size() < n) check({tag, " timeout"}, got_d.size(), n);
      repeat (8) @(negedge ft_clk);
   endtask

   task automatic check_beat(input string tag, input int unsigned idx,
                             input logic [7:0] d, input logic l, input logic e);
      if (idx < got_d.size()) begin
         check({tag, " data"}, got_d[idx], d);
         check({tag, " last"}, got_l[idx], l);
         check({tag, " err"},  got_e[idx], e);
      end else begin
         check({tag, " missing"}, idx, got_d.size());
      end
   endtask

   initial begin
      int unsigned bad_d, bad_l, n_last, c;
      logic [7:0]  exp_q [$];
      logic [7:0]  b, x;

      n_tests = 0;
      n_fail = 0;
      rd_empty_viol = 0;
      stall_viol = 0;
      rdy_pct = 100;
      ft_rst = 1'b0;

      // Reset state
      repeat (3) @(negedge ft_clk);
      check("rst m_valid", m_valid, 0);
      check("rst m_data", m_data, 0);
      check("rst m_last", m_last, 0);
      check("rst m_err", m_err, 0);
      check("rst rxfifo_rd", rxfifo_rd, 0);
      check("rst ok_cnt", frm_ok_cnt, 0);
      check("rst err_cnt", frm_err_cnt, 0);
      check("rst drop_cnt", drop_cnt, 0);
      ft_rst = 1'b1;
      repeat (2) @(negedge ft_clk);

      // Good frame
      clear_beats();
      push_bytes(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 6);
      wait_beats("good", 3, 100);
      check("good beats", got_d.size(), 3);
      check_beat("good b0", 0, 8'h11, 1'b0, 1'b0);
      check_beat("good b1", 1, 8'h22, 1'b0, 1'b0);
      check_beat("good b2", 2, 8'h33, 1'b1, 1'b0);
      check("good ok_cnt", frm_ok_cnt, 1);
      check("good err_cnt", frm_err_cnt, 0);

      // Bad checksum: expected CHK is 13
      clear_beats();
      push_bytes(8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00, 8'h00, 5);
      wait_beats("badchk", 2, 100);
      check("badchk beats", got_d.size(), 2);
      check_beat("badchk b0", 0, 8'hAA, 1'b0, 1'b0);
      check_beat("badchk b1", 1, 8'hBB, 1'b1, 1'b1);
      check("badchk err_cnt", frm_err_cnt, 1);
      check("badchk ok_cnt", frm_ok_cnt, 1);

      // Garbage ahead of a single-byte frame
      clear_beats();
      push_bytes(8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 6);
      push_bytes(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      wait_beats("garbage", 1, 100);
      check("garbage beats", got_d.size(), 1);
      check_beat("garbage b0", 0, 8'h7E, 1'b1, 1'b0);
      check("garbage drop_cnt", drop_cnt, 3);
      check("garbage ok_cnt", frm_ok_cnt, 2);

      // Illegal lengths 0 and 65, then a good frame
      clear_beats();
      push_bytes(8'hA5, 8'h00, 8'hA5, 8'h41, 8'h00, 8'h00, 4);
      repeat (20) @(negedge ft_clk);
      check("badlen beats", got_d.size(), 0);
      check("badlen err_cnt", frm_err_cnt, 3);
      check("badlen drop_cnt", drop_cnt, 3);
      push_bytes(8'hA5, 8'h02, 8'h01, 8'h02, 8'h01, 8'h00, 5);
      wait_beats("afterlen", 2, 100);
      check("afterlen beats", got_d.size(), 2);
      check_beat("afterlen b0", 0, 8'h01, 1'b0, 1'b0);
      check_beat("afterlen b1", 1, 8'h02, 1'b1, 1'b0);
      check("afterlen ok_cnt", frm_ok_cnt, 3);

      // Maximum length with SYNC-valued payload: 64 x A5, CHK = 40
      clear_beats();
      src_q.push_back(8'hA5);
      src_q.push_back(8'h40);
      for (int unsigned i = 0; i < 64; i++) src_q.push_back(8'hA5);
      src_q.push_back(8'h40);
      wait_beats("maxlen", 64, 300);
      check("maxlen beats", got_d.size(), 64);
      bad_d = 0;
      n_last = 0;
      for (int unsigned i = 0; i < got_d.size(); i++) begin
         if (got_d[i] != 8'hA5) bad_d++;
         if (got_l[i]) n_last++;
      end
      check("maxlen data errors", bad_d, 0);
      check("maxlen last count", n_last, 1);
      if (got_d.size() == 64) begin
         check("maxlen last pos", got_l[63], 1);
         check("maxlen err", got_e[63], 0);
      end
      check("maxlen ok_cnt", frm_ok_cnt, 4);

      // Backpressure: 10 back-to-back 8-byte frames, ready 30% of cycles
      clear_beats();
      exp_q.delete();
      for (int unsigned f = 0; f < 10; f++) begin
         src_q.push_back(8'hA5);
         src_q.push_back(8'h08);
         x = 8'h08;
         for (int unsigned j = 0; j < 8; j++) begin
            b = 8'(f * 8 + j + 1);
            if (j == 3) b = 8'hA5;
            src_q.push_back(b);
            exp_q.push_back(b);
            x = x ^ b;
         end
         src_q.push_back(x);
      end
      rdy_pct = 30;
      wait_beats("bp", 80, 3000);
      rdy_pct = 100;
      check("bp beats", got_d.size(), 80);
      bad_d = 0;
      bad_l = 0;
      for (int unsigned i = 0; i < got_d.size() && i < 80; i++) begin
         if (got_d[i] != exp_q[i]) bad_d++;
         if (got_l[i] != ((i % 8) == 7)) bad_l++;
         if (got_e[i]) bad_l++;
      end
      check("bp data errors", bad_d, 0);
      check("bp last/err errors", bad_l, 0);
      check("bp ok_cnt", frm_ok_cnt, 14);
      check("bp err_cnt", frm_err_cnt, 3);
      check("bp stall stability", stall_viol, 0);
      check("bp rd when empty", rd_empty_viol, 0);

      // Reset in the middle of a 16-byte payload
      clear_beats();
      src_q.push_back(8'hA5);
      src_q.push_back(8'h10);
      for (int unsigned i = 0; i < 16; i++) src_q.push_back(8'(8'h20 + i));
      src_q.push_back(8'h00);
      c = 0;
      while (got_d.size() < 4 && c < 100) begin
         @(negedge ft_clk);
         c++;
      end
      if (got_d.size() < 4) check("midrst timeout", got_d.size(), 4);
      @(posedge ft_clk);
      #2;
      ft_rst = 1'b0;
      src_q.delete();
      @(negedge ft_clk);
      check("midrst m_valid", m_valid, 0);
      check("midrst m_last", m_last, 0);
      check("midrst m_data", m_data, 0);
      check("midrst rxfifo_rd", rxfifo_rd, 0);
      check("midrst ok_cnt", frm_ok_cnt, 0);
      check("midrst err_cnt", frm_err_cnt, 0);
      repeat (3) @(negedge ft_clk);
      ft_rst = 1'b1;
      clear_beats();
      push_bytes(8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 6);
      wait_beats("postrst", 3, 100);
      check("postrst beats", got_d.size(), 3);
      check_beat("postrst b0", 0, 8'h11, 1'b0, 1'b0);
      check_beat("postrst b1", 1, 8'h22, 1'b0, 1'b0);
      check_beat("postrst b2", 2, 8'h33, 1'b1, 1'b0);
      check("postrst ok_cnt", frm_ok_cnt, 1);
      check("postrst err_cnt", frm_err_cnt, 0);
      check("postrst drop_cnt", drop_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
